// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, parameter limits
// and a constant-foldable clog2.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int unsigned NREQ_MIN    = 2;
  localparam int unsigned NREQ_MAX    = 8;
  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests so the slot after ptr sits at bit 0,
// take the lowest set bit, rotate the one-hot result back.
module rr_priority_pick
  import cpu_bus_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [PW-1:0]     start;
  logic [2*NREQ-1:0] dbl_req;
  logic [2*NREQ-1:0] dbl_pick;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   pick;

  always_comb begin
    start    = (ptr == PW'(NREQ - 1)) ? '0 : ptr + 1'b1;
    dbl_req  = {req, req} >> start;
    rot      = dbl_req[NREQ-1:0];
    pick     = rot & (~rot + 1'b1);
    dbl_pick = {pick, pick} << start;
    gnt      = dbl_pick[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises NREQ masters onto one single-port memory, one access at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   gnt_o,
  output logic [DW-1:0]     rdata_o,
  output logic              busy_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic [DW-1:0]     mem_rdata_i
);

  localparam int unsigned PW = clog2(NREQ);
  localparam int unsigned CW = clog2(MEM_LAT + 1);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("mem_bus_arbiter: NREQ=%0d outside %0d..%0d", NREQ, NREQ_MIN, NREQ_MAX);
  end
  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_bus_arbiter: MEM_LAT=%0d outside %0d..%0d", MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   lat_cnt, lat_cnt_nxt;
  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] ack_nxt, gnt_nxt;
  logic [DW-1:0]   rdata_nxt, mem_wdata_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic            busy_nxt, mem_en_nxt, mem_we_nxt;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign win = req_i & (~req_i + 1'b1);
`else
  logic [PW-1:0] rr_ptr;

  rr_priority_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (win)
  );

  // Reset value NREQ-1 makes requester 0 the first to be searched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            rr_ptr <= PW'(NREQ - 1);
    else if (state == ST_IDLE && |req_i) rr_ptr <= win_idx;
  end
`endif

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (win[i]) win_idx = PW'(i);
  end

  always_comb begin
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    ack_nxt       = '0;
    gnt_nxt       = gnt_o;
    rdata_nxt     = rdata_o;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = mem_we_o;
    mem_addr_nxt  = mem_addr_o;
    mem_wdata_nxt = mem_wdata_o;
    case (state)
      ST_IDLE: begin
        if (|req_i) begin
          state_nxt     = ST_ACCESS;
          lat_cnt_nxt   = CW'(MEM_LAT);
          gnt_nxt       = win;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = we_i[win_idx];
          mem_addr_nxt  = addr_i[32'(win_idx) * AW +: AW];
          mem_wdata_nxt = wdata_i[32'(win_idx) * DW +: DW];
        end
      end
      ST_ACCESS: begin
        // Last ACCESS cycle: memory data is sampled into rdata_o on this edge.
        if (lat_cnt == CW'(1)) begin
          state_nxt = ST_RESP;
          ack_nxt   = gnt_o;
          if (!mem_we_o) rdata_nxt = mem_rdata_i;
        end else begin
          lat_cnt_nxt = lat_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      ack_o       <= '0;
      gnt_o       <= '0;
      rdata_o     <= '0;
      busy_o      <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      ack_o       <= ack_nxt;
      gnt_o       <= gnt_nxt;
      rdata_o     <= rdata_nxt;
      busy_o      <= busy_nxt;
      mem_en_o    <= mem_en_nxt;
      mem_we_o    <= mem_we_nxt;
      mem_addr_o  <= mem_addr_nxt;
      mem_wdata_o <= mem_wdata_nxt;
    end
  end

endmodule
